// File: rtl/flag_reg_stack.sv
// Status-flag register with masked ALU writes and a LIFO save/restore stack
// for nested interrupt entry/return.
module flag_reg_stack #(
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic                       we,
  input  logic [NFLAGS-1:0]          wmask,
  input  logic [NFLAGS-1:0]          flags_i,
  input  logic                       push,
  input  logic [NFLAGS-1:0]          int_flags_i,
  input  logic                       pop,
  input  logic                       err_clr,
  output logic [NFLAGS-1:0]          flags_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ovf_o,
  output logic                       unf_o
);

  localparam int unsigned DW = $clog2(DEPTH+1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] stack [2**AW];
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     top_idx;

  assign full_o  = (depth_o == DW'(DEPTH));
  assign empty_o = (depth_o == '0);
  assign wr_idx  = AW'(depth_o);
  assign top_idx = AW'(depth_o - DW'(1));

  // Live flags, depth and sticky errors; stack contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_o <= '0;
      depth_o <= '0;
      ovf_o   <= 1'b0;
      unf_o   <= 1'b0;
    end else if (clk_en) begin
      if (err_clr) begin
        ovf_o <= 1'b0;
        unf_o <= 1'b0;
      end
      if (push && pop && !empty_o) begin
        // Swap: replace the top saved word without changing depth.
        stack[top_idx] <= flags_o;
        flags_o        <= int_flags_i;
      end else if (push) begin
        if (!full_o) begin
          stack[wr_idx] <= flags_o;
          depth_o       <= depth_o + DW'(1);
        end else begin
          ovf_o <= 1'b1;
        end
        flags_o <= int_flags_i;
      end else if (pop) begin
        if (!empty_o) begin
          flags_o <= stack[top_idx];
          depth_o <= depth_o - DW'(1);
        end else begin
          unf_o <= 1'b1;
        end
      end else if (we) begin
        flags_o <= (flags_o & ~wmask) | (flags_i & wmask);
      end
    end
  end

endmodule
